// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the leading-zero-count / normalize pipeline.
package lzc_pkg;

   // Operand is scanned in groups of this many bits.
   localparam int GRP_W = 4;

   // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/lzc_nibble.sv
// Leading-zero position inside one 4-bit group; purely combinational.
module lzc_nibble
   import lzc_pkg::*;
(
   input  logic [GRP_W-1:0] nib_i,
   output logic             nz_o,
   output logic [1:0]       pos_o
);

   assign nz_o = |nib_i;

   // Position of the highest set bit counted from the group MSB; 0 when empty.
   always_comb begin
      pos_o = 2'd0;
      casez (nib_i)
         4'b1???: pos_o = 2'd0;
         4'b01??: pos_o = 2'd1;
         4'b001?: pos_o = 2'd2;
         4'b0001: pos_o = 2'd3;
         default: pos_o = 2'd0;
      endcase
   end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero count and left-normalize with valid/ready flow control.
// Stage 1 registers per-group flags/positions, stage 2 combines them and shifts.
module lzc_norm_pipe
   import lzc_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int TAG_W = 4,
   localparam int CNT_W = clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_zero,
   output logic [WIDTH-1:0] out_norm,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NG = WIDTH / GRP_W;

   logic [NG-1:0]       grp_nz;
   logic [NG-1:0][1:0]  grp_pos;

   logic                s1_valid_q;
   logic [NG-1:0]       s1_nz_q;
   logic [NG-1:0][1:0]  s1_pos_q;
   logic [WIDTH-1:0]    s1_data_q;
   logic [TAG_W-1:0]    s1_tag_q;

   logic                s2_valid_q;
   logic [CNT_W-1:0]    s2_count_q;
   logic                s2_zero_q;
   logic [WIDTH-1:0]    s2_norm_q;
   logic [TAG_W-1:0]    s2_tag_q;

   logic [CNT_W-1:0]    count_d;
   logic                zero_d;
   logic [WIDTH-1:0]    norm_d;

   logic                s1_advance;
   logic                in_fire;
   logic                out_fire;

   // Group g covers in_data[4g+3:4g]; group NG-1 holds the MSBs.
   for (genvar g = 0; g < NG; g++) begin : g_nib
      lzc_nibble u_nib (
         .nib_i (in_data[g*GRP_W +: GRP_W]),
         .nz_o  (grp_nz[g]),
         .pos_o (grp_pos[g])
      );
   end

   // Ready path is combinational from out_ready so a full pipe still streams.
   assign out_fire   = s2_valid_q & out_ready;
   assign s1_advance = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready   = ~s1_valid_q | s1_advance;
   assign in_fire    = in_valid & in_ready & ~rst;

   // Stage 1: capture per-group results along with the raw operand and tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_nz_q    <= '0;
         s1_pos_q   <= '0;
         s1_data_q  <= '0;
         s1_tag_q   <= '0;
      end else if (in_fire) begin
         s1_valid_q <= 1'b1;
         s1_nz_q    <= grp_nz;
         s1_pos_q   <= grp_pos;
         s1_data_q  <= in_data;
         s1_tag_q   <= in_tag;
      end else if (s1_advance) begin
         s1_valid_q <= 1'b0;
      end
   end

   // Priority select: the most significant nonzero group wins (later loop pass overrides).
   always_comb begin
      zero_d  = 1'b1;
      count_d = CNT_W'(WIDTH);
      for (int g = 0; g < NG; g++) begin
         if (s1_nz_q[g]) begin
            zero_d  = 1'b0;
            count_d = CNT_W'((NG - 1 - g) * GRP_W) + CNT_W'(s1_pos_q[g]);
         end
      end
      norm_d = s1_data_q << count_d;
   end

   // Stage 2: output registers hold steady while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_count_q <= '0;
         s2_zero_q  <= 1'b0;
         s2_norm_q  <= '0;
         s2_tag_q   <= '0;
      end else if (s1_advance) begin
         s2_valid_q <= 1'b1;
         s2_count_q <= count_d;
         s2_zero_q  <= zero_d;
         s2_norm_q  <= norm_d;
         s2_tag_q   <= s1_tag_q;
      end else if (out_fire) begin
         s2_valid_q <= 1'b0;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_count = s2_count_q;
   assign out_zero  = s2_zero_q;
   assign out_norm  = s2_norm_q;
   assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed bench for lzc_norm_pipe at WIDTH=16, TAG_W=4.
module tb_lzc_norm_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_count;
   logic        out_zero;
   logic [15:0] out_norm;
   logic [3:0]  out_tag;

   int n_vec  = 0;
   int n_miss = 0;

   lzc_norm_pipe #(.WIDTH(16), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_count (out_count),
      .out_zero  (out_zero),
      .out_norm  (out_norm),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Entered just after a rising edge with an empty pipe; leaves the same way.
   task automatic send_one(input string nm, input logic [15:0] d, input logic [3:0] t,
                           input logic [4:0] ec, input logic ez, input logic [15:0] en);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_tag    = t;
      chk({nm, "_rdy"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      in_data   = 16'hDEAD;
      in_tag    = 4'hF;
      @(negedge clk);
      chk({nm, "_lat1"}, out_valid, 0);
      @(negedge clk);
      chk({nm, "_vld"},  out_valid, 1);
      chk({nm, "_cnt"},  out_count, ec);
      chk({nm, "_zero"}, out_zero,  ez);
      chk({nm, "_norm"}, out_norm,  en);
      chk({nm, "_tag"},  out_tag,   t);
      @(negedge clk);
      chk({nm, "_drain"}, out_valid, 0);
      @(posedge clk); #1;
   endtask

   logic [15:0] s_data [3];
   logic [3:0]  s_tag  [3];
   logic [4:0]  s_cnt  [3];
   logic [15:0] s_norm [3];

   initial begin
      int exp_tag;
      int nt;
      logic acc;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_tag = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_vld",  out_valid, 0);
      chk("rst_rdy",  in_ready,  1);
      chk("rst_cnt",  out_count, 0);
      chk("rst_zero", out_zero,  0);
      chk("rst_norm", out_norm,  0);
      chk("rst_tag",  out_tag,   0);
      @(posedge clk); #1;

      // Single words, hand-computed results.
      send_one("v0001", 16'h0001, 4'd3, 5'd15, 1'b0, 16'h8000);
      send_one("v0000", 16'h0000, 4'd1, 5'd16, 1'b1, 16'h0000);
      send_one("v8000", 16'h8000, 4'd2, 5'd0,  1'b0, 16'h8000);
      send_one("v00F0", 16'h00F0, 4'd4, 5'd8,  1'b0, 16'hF000);
      send_one("v0A00", 16'h0A00, 4'd5, 5'd4,  1'b0, 16'hA000);
      send_one("v0010", 16'h0010, 4'd6, 5'd11, 1'b0, 16'h8000);
      send_one("v3FFF", 16'h3FFF, 4'd7, 5'd2,  1'b0, 16'hFFFC);
      send_one("v0123", 16'h0123, 4'd0, 5'd7,  1'b0, 16'h9180);

      // Back-to-back stream with out_ready held high: one result per cycle.
      s_data = '{16'h1234, 16'h0007, 16'hFFFF};
      s_tag  = '{4'd8, 4'd9, 4'd10};
      s_cnt  = '{5'd3, 5'd13, 5'd0};
      s_norm = '{16'h91A0, 16'hE000, 16'hFFFF};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i < 3) begin
            in_valid = 1'b1; in_data = s_data[i]; in_tag = s_tag[i];
            chk("tp_rdy", in_ready, 1);
         end else begin
            in_valid = 1'b0; in_data = 16'hBEEF;
         end
         @(negedge clk);
         if (i >= 2 && i <= 4) begin
            chk("tp_vld",  out_valid, 1);
            chk("tp_tag",  out_tag,  s_tag[i-2]);
            chk("tp_cnt",  out_count, s_cnt[i-2]);
            chk("tp_norm", out_norm, s_norm[i-2]);
         end else begin
            chk("tp_idle", out_valid, 0);
         end
         @(posedge clk); #1;
      end

      // Backpressure: out_ready low for 4 cycles while tags 1..4 are offered.
      exp_tag = 1;
      nt = 1;
      in_valid = 1'b1; in_tag = 4'd1; in_data = 16'h0004;
      for (int cyc = 0; cyc < 12; cyc++) begin
         out_ready = (cyc >= 4);
         if (cyc < 4) chk("bp_rdy", in_ready, (cyc < 2) ? 1 : 0);
         @(negedge clk);
         if (cyc == 1) chk("bp_lat", out_valid, 0);
         if (cyc == 2 || cyc == 3) begin
            chk("bp_hold_vld",  out_valid, 1);
            chk("bp_hold_tag",  out_tag,   1);
            chk("bp_hold_cnt",  out_count, 13);
            chk("bp_hold_norm", out_norm,  16'h8000);
         end
         if (out_ready && out_valid) begin
            chk("bp_order", out_tag, exp_tag);
            chk("bp_cnt",   out_count, 15 - 2*exp_tag);
            exp_tag++;
         end else if (out_ready && exp_tag > 1 && exp_tag < 5) begin
            chk("bp_gap", out_valid, 1);
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            nt++;
            if (nt <= 4) begin
               in_tag  = 4'(nt);
               in_data = 16'h0001 << (2*nt);
            end else begin
               in_valid = 1'b0;
               in_data  = 16'h5555;
            end
         end
      end
      chk("bp_all", exp_tag, 5);

      // Reset with both stages full: stale words and the word offered during reset vanish.
      out_ready = 1'b0;
      in_valid = 1'b1; in_tag = 4'd5; in_data = 16'h0001;
      @(posedge clk); #1;
      in_tag = 4'd6; in_data = 16'h0002;
      @(posedge clk); #1;
      rst = 1'b1; in_tag = 4'd7; in_data = 16'h00FF;
      @(negedge clk);
      chk("full_vld", out_valid, 1);
      chk("full_rdy", in_ready,  0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("mrst_vld",  out_valid, 0);
      chk("mrst_rdy",  in_ready,  1);
      chk("mrst_cnt",  out_count, 0);
      chk("mrst_zero", out_zero,  0);
      chk("mrst_norm", out_norm,  0);
      chk("mrst_tag",  out_tag,   0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mrst_stale", out_valid, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
